// File: rtl/i2c_slave_sync.sv
// I2C target running entirely on the system clock: oversampled SCL/SDA, START/STOP
// detection, address match with ACK, and unbounded byte transfers over ready/valid.
module i2c_slave_sync #(
   parameter int                  ADDR_LEN    = 7,
   parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'b1011011,
   parameter int                  DATA_LEN    = 8,
   parameter int                  SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scl_in,
   input  logic                sda_in,
   output logic                sda_oe,
   output logic [DATA_LEN-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   input  logic [DATA_LEN-1:0] tx_data,
   output logic                tx_req,
   output logic                rw,
   output logic                busy
);

   localparam int CNT_W = $clog2(DATA_LEN + 2);
   localparam int SH_W  = (ADDR_LEN > DATA_LEN - 1) ? ADDR_LEN : DATA_LEN - 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_LEN - 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start, stop;

   state_t                 state, state_d;
   logic [CNT_W-1:0]       cnt, cnt_d, cnt_inc;
   logic [SH_W-1:0]        rx_shift, rx_shift_d;
   logic [DATA_LEN-2:0]    tx_shift, tx_shift_d;
   logic                   ack_q, ack_d;
   logic                   phase, phase_d;
   logic                   sda_oe_d, rx_valid_d, tx_req_d, rw_d, busy_d;
   logic [DATA_LEN-1:0]    rx_data_d;

   assign scl_s    = scl_sync[SYNC_STAGES-1];
   assign sda_s    = sda_sync[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start    = scl_s & scl_d & sda_d & ~sda_s;
   assign stop     = scl_s & scl_d & ~sda_d & sda_s;
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

   // NOTE: every next-state signal is defaulted first so no path can infer a latch.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      rx_shift_d = rx_shift;
      tx_shift_d = tx_shift;
      ack_d      = ack_q;
      phase_d    = phase;
      sda_oe_d   = sda_oe;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      rw_d       = rw;
      busy_d     = busy;
      if (start) begin
         state_d  = ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         unique case (state)
            IDLE, WAIT_STOP: begin
               sda_oe_d = 1'b0;
               busy_d   = 1'b0;
            end
            ADDR: if (scl_rise) begin
               if (cnt == ADDR_LAST) begin
                  if (rx_shift[ADDR_LEN-1:0] == SLAVE_ADDR) begin
                     rw_d    = sda_s;
                     busy_d  = 1'b1;
                     phase_d = 1'b0;
                     state_d = ADDR_ACK;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end else begin
                  rx_shift_d = {rx_shift[SH_W-2:0], sda_s};
                  cnt_d      = cnt_inc;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               if (!phase) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 1'b1;
               end else if (rw) begin
                  tx_shift_d = tx_data[DATA_LEN-2:0];
                  tx_req_d   = 1'b1;
                  sda_oe_d   = ~tx_data[DATA_LEN-1];
                  cnt_d      = '0;
                  state_d    = RD_DATA;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = WR_DATA;
               end
            end
            WR_DATA: if (scl_rise) begin
               rx_shift_d = {rx_shift[SH_W-2:0], sda_s};
               if (cnt == DATA_LAST) begin
                  ack_d   = rx_ready;
                  phase_d = 1'b0;
                  state_d = WR_ACK;
                  if (rx_ready) begin
                     rx_data_d  = {rx_shift[DATA_LEN-2:0], sda_s};
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            WR_ACK: if (scl_fall) begin
               if (!ack_q) begin
                  sda_oe_d = 1'b0;
                  busy_d   = 1'b0;
                  state_d  = WAIT_STOP;
               end else if (!phase) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 1'b1;
               end else begin
                  sda_oe_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = WR_DATA;
               end
            end
            RD_DATA: if (scl_fall) begin
               if (cnt == DATA_LAST) begin
                  sda_oe_d = 1'b0;
                  state_d  = RD_ACK;
               end else begin
                  sda_oe_d   = ~tx_shift[DATA_LEN-2];
                  tx_shift_d = {tx_shift[DATA_LEN-3:0], 1'b0};
                  cnt_d      = cnt_inc;
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  ack_d = ~sda_s;
               end else if (scl_fall) begin
                  if (ack_q) begin
                     tx_shift_d = tx_data[DATA_LEN-2:0];
                     tx_req_d   = 1'b1;
                     sda_oe_d   = ~tx_data[DATA_LEN-1];
                     cnt_d      = '0;
                     state_d    = RD_DATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     busy_d   = 1'b0;
                     state_d  = WAIT_STOP;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
         state    <= IDLE;
         cnt      <= '0;
         ack_q    <= 1'b0;
         phase    <= 1'b0;
         sda_oe   <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         rw       <= 1'b0;
         busy     <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
         state    <= state_d;
         cnt      <= cnt_d;
         ack_q    <= ack_d;
         phase    <= phase_d;
         sda_oe   <= sda_oe_d;
         rx_data  <= rx_data_d;
         rx_valid <= rx_valid_d;
         tx_req   <= tx_req_d;
         rw       <= rw_d;
         busy     <= busy_d;
      end
   end

   // NOTE: shift registers carry no reset; each is fully written before it is read.
   always_ff @(posedge clk) begin
      rx_shift <= rx_shift_d;
      tx_shift <= tx_shift_d;
   end

endmodule

// File: tb/tb_i2c_slave_sync.sv
// Bench for i2c_slave_sync: a bit-level bus master drives table-driven write
// transactions, then hand-written read, back-pressure, repeated-START and reset cases.
`timescale 1ns/1ps
module tb_i2c_slave_sync;

   localparam int Q = 8;  // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_req;
   logic       rw;
   logic       busy;

   assign sda_bus = sda_m & ~sda_oe;

   i2c_slave_sync dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_m),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .rw       (rw),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int rxv_cnt = 0;
   int txr_cnt = 0;
   int oe_cyc  = 0;
   always @(posedge clk) begin
      if (rx_valid) rxv_cnt <= rxv_cnt + 1;
      if (tx_req)   txr_cnt <= txr_cnt + 1;
      if (sda_oe)   oe_cyc  <= oe_cyc + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, output logic r);
      sda_m = b;
      clk_wait(Q);
      scl_m = 1'b1;
      clk_wait(Q);
      r = sda_bus;
      clk_wait(Q);
      scl_m = 1'b0;
      clk_wait(Q);
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      clk_wait(Q);
      scl_m = 1'b1;
      clk_wait(2 * Q);
      sda_m = 1'b0;
      clk_wait(2 * Q);
      scl_m = 1'b0;
      clk_wait(Q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      clk_wait(Q);
      scl_m = 1'b1;
      clk_wait(2 * Q);
      sda_m = 1'b1;
      clk_wait(2 * Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
      bit_xfer(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, r);
         b[i] = r;
      end
      bit_xfer(~mack, r);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       rdy;
      logic       aack;
      logic       dack;
      int         rxv;
      logic [7:0] rx;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       a, d;
      logic [7:0] b1, b2;
      int         rxv0, oe0, txr0;

      vecs[0] = '{8'hB6, 8'hA5, 1'b1, 1'b1, 1'b1, 1, 8'hA5};
      vecs[1] = '{8'hB4, 8'h12, 1'b1, 1'b0, 1'b0, 0, 8'hA5};
      vecs[2] = '{8'hB6, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h00};
      vecs[3] = '{8'hB6, 8'hFF, 1'b1, 1'b1, 1'b1, 1, 8'hFF};
      vecs[4] = '{8'hB6, 8'h5A, 1'b0, 1'b1, 1'b0, 0, 8'hFF};
      vecs[5] = '{8'h36, 8'h77, 1'b1, 1'b0, 1'b0, 0, 8'hFF};

      clk_wait(4);
      check("reset sda_oe",   sda_oe,   0);
      check("reset rx_valid", rx_valid, 0);
      check("reset tx_req",   tx_req,   0);
      check("reset busy",     busy,     0);
      check("reset rw",       rw,       0);
      check("reset rx_data",  rx_data,  0);
      rst = 1'b0;
      clk_wait(4);

      for (int i = 0; i < 6; i++) begin
         rx_ready = vecs[i].rdy;
         rxv0 = rxv_cnt;
         oe0  = oe_cyc;
         bus_start();
         write_byte(vecs[i].addr, a);
         check($sformatf("v%0d addr_ack", i), a, vecs[i].aack);
         check($sformatf("v%0d busy_addr", i), busy, vecs[i].aack);
         write_byte(vecs[i].data, d);
         check($sformatf("v%0d data_ack", i), d, vecs[i].dack);
         check($sformatf("v%0d busy_data", i), busy, vecs[i].dack);
         bus_stop();
         check($sformatf("v%0d rx_valid_cnt", i), rxv_cnt - rxv0, vecs[i].rxv);
         check($sformatf("v%0d rx_data", i), rx_data, vecs[i].rx);
         check($sformatf("v%0d busy_stop", i), busy, 0);
         check($sformatf("v%0d oe_seen", i), (oe_cyc != oe0), vecs[i].aack);
      end

      // Multi-byte read: master ACKs byte 1, NACKs byte 2.
      rx_ready = 1'b1;
      tx_data  = 8'h3C;
      txr0 = txr_cnt;
      bus_start();
      write_byte(8'hB7, a);
      check("rd addr_ack", a, 1);
      check("rd rw", rw, 1);
      check("rd busy", busy, 1);
      check("rd tx_req first", txr_cnt - txr0, 1);
      tx_data = 8'hC3;
      read_byte(1'b1, b1);
      read_byte(1'b0, b2);
      check("rd byte1", b1, 8'h3C);
      check("rd byte2", b2, 8'hC3);
      check("rd tx_req total", txr_cnt - txr0, 2);
      check("rd released", sda_oe, 0);
      check("rd busy after nack", busy, 0);
      bus_stop();
      check("rd idle sda_oe", sda_oe, 0);

      // Write back-pressure: second byte refused.
      rxv0 = rxv_cnt;
      bus_start();
      write_byte(8'hB6, a);
      check("bp addr_ack", a, 1);
      write_byte(8'h11, d);
      check("bp byte1 ack", d, 1);
      check("bp rx_data1", rx_data, 8'h11);
      rx_ready = 1'b0;
      write_byte(8'h22, d);
      check("bp byte2 nack", d, 0);
      check("bp rx_valid_cnt", rxv_cnt - rxv0, 1);
      check("bp rx_data kept", rx_data, 8'h11);
      check("bp busy", busy, 0);
      write_byte(8'h33, d);
      check("bp wait_stop ignores", d, 0);
      bus_stop();
      rx_ready = 1'b1;

      // Repeated START: write then read without STOP.
      tx_data = 8'h96;
      bus_start();
      write_byte(8'hB6, a);
      check("sr w addr_ack", a, 1);
      check("sr rw before", rw, 0);
      write_byte(8'h55, d);
      check("sr w data_ack", d, 1);
      check("sr rx_data", rx_data, 8'h55);
      txr0 = txr_cnt;
      bus_start();
      write_byte(8'hB7, a);
      check("sr r addr_ack", a, 1);
      check("sr rw after", rw, 1);
      read_byte(1'b0, b1);
      check("sr read byte", b1, 8'h96);
      check("sr tx_req cnt", txr_cnt - txr0, 1);
      bus_stop();

      // Reset while the address ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = 8'hB6;
         bit_xfer(ab[i], a);
      end
      check("rst pre sda_oe", sda_oe, 1);
      rst = 1'b1;
      clk_wait(1);
      check("rst sda_oe", sda_oe, 0);
      check("rst busy", busy, 0);
      check("rst rw", rw, 0);
      check("rst rx_data", rx_data, 0);
      check("rst rx_valid", rx_valid, 0);
      check("rst tx_req", tx_req, 0);
      clk_wait(1);
      rst = 1'b0;
      clk_wait(2);
      bus_stop();
      rxv0 = rxv_cnt;
      bus_start();
      write_byte(8'hB6, a);
      check("post rst addr_ack", a, 1);
      write_byte(8'h3C, d);
      check("post rst data_ack", d, 1);
      bus_stop();
      check("post rst rx_data", rx_data, 8'h3C);
      check("post rst rx_valid_cnt", rxv_cnt - rxv0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
